lbdr_dr: RTL and testbench

LBDR_DR -- requirements
Module: lbdr_dr

---
 rtl/lbdr_dr.sv | 176 +++++++++++++++++
 tb/tb_lbdr_dr.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbdr_dr.sv
// Logic-Based Distributed Routing unit with deroute fallback.
// Computes a one-hot output-port request for each packet header using the
// active Rxy/Cx/dr configuration. Runtime reconfiguration goes through a
// shadow register and takes effect only between packets.
module lbdr_dr #(
  parameter int              AXIS      = 4,
  parameter int              FT_W      = 3,
  parameter logic [FT_W-1:0] HDR_CODE  = 3'b001,
  parameter logic [FT_W-1:0] TAIL_CODE = 3'b100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            empty,
  input  logic [FT_W-1:0] flit_type,
  input  logic [AXIS-1:0] dst_addr,
  input  logic            flit_rd,
  input  logic [7:0]      Rxy_rst,
  input  logic [3:0]      Cx_rst,
  input  logic [1:0]      dr_rst,
  input  logic [AXIS-1:0] cur_addr_rst,
  input  logic            cfg_we,
  input  logic [7:0]      cfg_Rxy,
  input  logic [3:0]      cfg_Cx,
  input  logic [1:0]      cfg_dr,
  output logic [4:0]      req,
  output logic            route_valid,
  output logic            drop,
  output logic            route_err,
  output logic            cfg_pending
);

  localparam int HW = AXIS / 2;

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t          state;

  // Active configuration. Bit layouts:
  //   rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
  //   cx  = {Cs,Cw,Ce,Cn}; dr codes 0=N,1=E,2=W,3=S share the cx bit index.
  logic [7:0]      rxy;
  logic [3:0]      cx;
  logic [1:0]      dr;
  logic [AXIS-1:0] cur_addr;

  // Shadow configuration waiting for the next packet boundary.
  logic [7:0]      shadow_rxy;
  logic [3:0]      shadow_cx;
  logic [1:0]      shadow_dr;

  logic [HW-1:0]   x_cur, y_cur, x_dst, y_dst;
  logic            n1, s1, e1, w1;
  logic            cand_l, cand_n, cand_e, cand_w, cand_s;
  logic [4:0]      sel_req;
  logic            routable;
  logic            hdr_head;
  logic            hdr_accept;
  logic            tail_read;
  logic            apply_cfg;

  assign x_cur = cur_addr[HW-1:0];
  assign y_cur = cur_addr[AXIS-1:HW];
  assign x_dst = dst_addr[HW-1:0];
  assign y_dst = dst_addr[AXIS-1:HW];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  // Minimal-path candidates: straight moves need only connectivity, diagonal
  // moves additionally need the matching turn bit.
  assign cand_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
  assign cand_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
  assign cand_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
  assign cand_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];
  assign cand_l = ~n1 & ~s1 & ~e1 & ~w1;

  assign hdr_head   = ~empty & (flit_type == HDR_CODE);
  assign hdr_accept = (state == IDLE) & hdr_head;
  assign tail_read  = flit_rd & ~empty & (flit_type == TAIL_CODE);
  // Config may change only between packets, and never under a header being
  // routed with the current values.
  assign apply_cfg  = (cfg_pending | cfg_we) & (state == IDLE) & ~hdr_head;

  // Priority select L > N > E > W > S, falling back to the deroute port.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    sel_req  = '0;
    routable = 1'b1;
    if (cand_l)      sel_req[4]  = 1'b1;
    else if (cand_n) sel_req[0]  = 1'b1;
    else if (cand_e) sel_req[1]  = 1'b1;
    else if (cand_w) sel_req[2]  = 1'b1;
    else if (cand_s) sel_req[3]  = 1'b1;
    else if (cx[dr]) sel_req[dr] = 1'b1;
    else             routable    = 1'b0;
  end

  // Configuration registers: reset load, shadow capture and deferred apply.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      rxy         <= Rxy_rst;
      cx          <= Cx_rst;
      dr          <= dr_rst;
      cur_addr    <= cur_addr_rst;
      shadow_rxy  <= '0;
      shadow_cx   <= '0;
      shadow_dr   <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_we) begin
        shadow_rxy <= cfg_Rxy;
        shadow_cx  <= cfg_Cx;
        shadow_dr  <= cfg_dr;
      end
      if (apply_cfg) begin
        // A write landing on the apply edge is the newest value, so it wins.
        rxy         <= cfg_we ? cfg_Rxy : shadow_rxy;
        cx          <= cfg_we ? cfg_Cx  : shadow_cx;
        dr          <= cfg_we ? cfg_dr  : shadow_dr;
        cfg_pending <= 1'b0;
      end else if (cfg_we) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  // Packet FSM with registered request outputs; route_err is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req         <= '0;
      route_valid <= 1'b0;
      drop        <= 1'b0;
      route_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req         <= '0;
          route_valid <= 1'b0;
          drop        <= 1'b0;
          if (hdr_accept) begin
            if (routable) begin
              req         <= sel_req;
              route_valid <= 1'b1;
              state       <= ROUTE;
            end else begin
              drop      <= 1'b1;
              route_err <= 1'b1;
              state     <= DROP;
            end
          end
        end
        ROUTE, DROP: begin
          if (tail_read) begin
            req         <= '0;
            route_valid <= 1'b0;
            drop        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          req         <= '0;
          route_valid <= 1'b0;
          drop        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbdr_dr.sv
// Self-checking bench for lbdr_dr: directed scenarios with fixed expected
// values, then randomized traffic against a behavioural routing model.
module tb_lbdr_dr;

  localparam int         AXIS = 4;
  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;
  localparam logic [2:0] BODY = 3'b010;

  logic       clk;
  logic       rst;
  logic       empty;
  logic [2:0] flit_type;
  logic [3:0] dst_addr;
  logic       flit_rd;
  logic [7:0] Rxy_rst;
  logic [3:0] Cx_rst;
  logic [1:0] dr_rst;
  logic [3:0] cur_addr_rst;
  logic       cfg_we;
  logic [7:0] cfg_Rxy;
  logic [3:0] cfg_Cx;
  logic [1:0] cfg_dr;
  logic [4:0] req;
  logic       route_valid;
  logic       drop;
  logic       route_err;
  logic       cfg_pending;

  int checks = 0;
  int errors = 0;

  // Model state for the randomized test.
  int         m_state;  // 0 idle, 1 routing, 2 dropping
  logic [4:0] m_req;
  logic       m_rv, m_drop, m_err, m_pend;
  logic [7:0] m_rxy, s_rxy;
  logic [3:0] m_cx, s_cx, m_cur;
  logic [1:0] m_dr, s_dr;

  lbdr_dr #(.AXIS(AXIS), .FT_W(3), .HDR_CODE(HDR), .TAIL_CODE(TAIL)) dut (
    .clk(clk), .rst(rst), .empty(empty), .flit_type(flit_type),
    .dst_addr(dst_addr), .flit_rd(flit_rd), .Rxy_rst(Rxy_rst),
    .Cx_rst(Cx_rst), .dr_rst(dr_rst), .cur_addr_rst(cur_addr_rst),
    .cfg_we(cfg_we), .cfg_Rxy(cfg_Rxy), .cfg_Cx(cfg_Cx), .cfg_dr(cfg_dr),
    .req(req), .route_valid(route_valid), .drop(drop),
    .route_err(route_err), .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] ft, input logic [3:0] d,
                       input logic rd);
    empty = e; flit_type = ft; dst_addr = d; flit_rd = rd;
  endtask

  // Writes a configuration while idle so it takes effect on that edge.
  task automatic cfg_now(input logic [7:0] r, input logic [3:0] c, input logic [1:0] d);
    drive(1'b1, BODY, 4'h0, 1'b0);
    cfg_we = 1'b1; cfg_Rxy = r; cfg_Cx = c; cfg_dr = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Port chosen by the routing rules: 0=N 1=E 2=W 3=S 4=L, -1 unroutable.
  // Directions are tried in priority order; a move that also needs a
  // perpendicular step is allowed only when its turn bit is set.
  function automatic int ref_route(input logic [3:0] cur, input logic [3:0] dst,
                                   input logic [7:0] rxy, input logic [3:0] cx,
                                   input logic [1:0] dr);
    int  cxv, cyv, dxv, dyv;
    bit  go [4];
    bit  vertical, has_perp, second;
    cxv = int'(cur[1:0]); cyv = int'(cur[3:2]);
    dxv = int'(dst[1:0]); dyv = int'(dst[3:2]);
    go[0] = dyv < cyv;
    go[1] = cxv < dxv;
    go[2] = dxv < cxv;
    go[3] = cyv < dyv;
    if (!(go[0] || go[1] || go[2] || go[3])) return 4;
    for (int d = 0; d < 4; d++) begin
      if (go[d] && cx[d]) begin
        vertical = (d == 0) || (d == 3);
        has_perp = vertical ? (go[1] || go[2]) : (go[0] || go[3]);
        second   = vertical ? go[2] : go[3];
        if (!has_perp || rxy[2 * d + int'(second)]) return d;
      end
    end
    if (cx[dr]) return int'(dr);
    return -1;
  endfunction

  // Applies the current inputs to the model as the coming edge will.
  task automatic model_step();
    bit head, tail, apply;
    int port;
    if (rst) begin
      m_state = 0; m_req = '0; m_rv = 0; m_drop = 0; m_err = 0; m_pend = 0;
      m_rxy = Rxy_rst; m_cx = Cx_rst; m_dr = dr_rst; m_cur = cur_addr_rst;
      s_rxy = '0; s_cx = '0; s_dr = '0;
      return;
    end
    head  = !empty && flit_type == HDR;
    tail  = !empty && flit_rd && flit_type == TAIL;
    apply = (m_pend || cfg_we) && m_state == 0 && !head;
    port  = ref_route(m_cur, dst_addr, m_rxy, m_cx, m_dr);
    if (m_state == 0) begin
      m_req = '0; m_rv = 0; m_drop = 0;
      if (head && port >= 0) begin
        m_req[port] = 1'b1; m_rv = 1; m_state = 1;
      end else if (head) begin
        m_drop = 1; m_err = 1; m_state = 2;
      end
    end else if (tail) begin
      m_req = '0; m_rv = 0; m_drop = 0; m_state = 0;
    end
    if (cfg_we) begin
      s_rxy = cfg_Rxy; s_cx = cfg_Cx; s_dr = cfg_dr;
    end
    if (apply) begin
      m_rxy = s_rxy; m_cx = s_cx; m_dr = s_dr; m_pend = 0;
    end else if (cfg_we) begin
      m_pend = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, BODY, 4'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({req, route_valid, drop, route_err, cfg_pending} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b rv=%b drop=%b err=%b pend=%b, expected all zero",
               req, route_valid, drop, route_err, cfg_pending);
    end
  endtask

  task automatic test_routed_packet();
    drive(1'b0, HDR, 4'b0111, 1'b1); tick();
    checks++;
    if (req !== 5'b00010 || route_valid !== 1'b1) begin
      errors++; $display("FAIL routed_hdr: got req=%b rv=%b, expected 00010 1", req, route_valid);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b0, BODY, 4'h0, 1'b1);
      else       drive(1'b1, TAIL, 4'h0, 1'b1);  // empty gap: tail code ignored
      tick();
      checks++;
      if (req !== 5'b00010 || route_valid !== 1'b1) begin
        errors++; $display("FAIL routed_hold%0d: got req=%b rv=%b, expected 00010 1", i, req, route_valid);
      end
    end
    drive(1'b0, TAIL, 4'h0, 1'b1); tick();
    checks++;
    if (req !== 5'b0 || route_valid !== 1'b0) begin
      errors++; $display("FAIL routed_tail: got req=%b rv=%b, expected 00000 0", req, route_valid);
    end
  endtask

  task automatic test_diagonal();
    drive(1'b0, HDR, 4'b0010, 1'b0); tick();
    checks++;
    if (req !== 5'b00001) begin
      errors++; $display("FAIL diag_deroute: got req=%b, expected 00001", req);
    end
    drive(1'b0, TAIL, 4'h0, 1'b1); tick();
    cfg_now(8'h01, 4'hF, 2'd0);
    drive(1'b0, HDR, 4'b0010, 1'b0); tick();
    checks++;
    if (req !== 5'b00001 || route_valid !== 1'b1) begin
      errors++; $display("FAIL diag_minimal: got req=%b rv=%b, expected 00001 1", req, route_valid);
    end
    drive(1'b0, TAIL, 4'h0, 1'b1); tick();
    cfg_now(8'h00, 4'hF, 2'd0);
  endtask

  task automatic test_local();
    drive(1'b0, HDR, 4'b0101, 1'b0); tick();
    checks++;
    if (req !== 5'b10000 || route_valid !== 1'b1) begin
      errors++; $display("FAIL local: got req=%b rv=%b, expected 10000 1", req, route_valid);
    end
    drive(1'b0, TAIL, 4'h0, 1'b1); tick();
  endtask

  task automatic test_unroutable();
    cfg_now(8'h00, 4'b0001, 2'd1);
    drive(1'b0, HDR, 4'b0111, 1'b0); tick();
    checks++;
    if (req !== 5'b0 || drop !== 1'b1 || route_err !== 1'b1 || route_valid !== 1'b0) begin
      errors++; $display("FAIL unroutable_hdr: got req=%b drop=%b err=%b rv=%b, expected 00000 1 1 0",
                         req, drop, route_err, route_valid);
    end
    drive(1'b0, HDR, 4'b0101, 1'b1); tick();  // header code inside a packet is ignored
    checks++;
    if (drop !== 1'b1 || req !== 5'b0) begin
      errors++; $display("FAIL drop_hold: got drop=%b req=%b, expected 1 00000", drop, req);
    end
    drive(1'b0, TAIL, 4'h0, 1'b1); tick();
    checks++;
    if (drop !== 1'b0 || route_err !== 1'b1) begin
      errors++; $display("FAIL drop_tail: got drop=%b err=%b, expected 0 1", drop, route_err);
    end
    cfg_now(8'h00, 4'hF, 2'd0);
    checks++;
    if (route_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got err=%b, expected 1", route_err);
    end
  endtask

  task automatic test_deferred_cfg();
    drive(1'b0, HDR, 4'b0111, 1'b0); tick();
    drive(1'b0, BODY, 4'h0, 1'b1);
    cfg_we = 1'b1; cfg_Rxy = 8'h00; cfg_Cx = 4'b1101; cfg_dr = 2'd0;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_pending !== 1'b1 || req !== 5'b00010) begin
      errors++; $display("FAIL defer_mid: got pend=%b req=%b, expected 1 00010", cfg_pending, req);
    end
    drive(1'b0, TAIL, 4'h0, 1'b1); tick();
    checks++;
    if (cfg_pending !== 1'b1 || req !== 5'b0) begin
      errors++; $display("FAIL defer_after_tail: got pend=%b req=%b, expected 1 00000", cfg_pending, req);
    end
    drive(1'b1, BODY, 4'h0, 1'b0); tick();
    checks++;
    if (cfg_pending !== 1'b0) begin
      errors++; $display("FAIL defer_applied: got pend=%b, expected 0", cfg_pending);
    end
    drive(1'b0, HDR, 4'b0111, 1'b0); tick();
    checks++;
    if (req !== 5'b00001) begin
      errors++; $display("FAIL defer_new_route: got req=%b, expected 00001", req);
    end
    drive(1'b0, TAIL, 4'h0, 1'b1); tick();
  endtask

  task automatic test_reset_mid_packet();
    drive(1'b0, HDR, 4'b0111, 1'b0); tick();
    checks++;
    if (req !== 5'b00001) begin
      errors++; $display("FAIL rst_pre_route: got req=%b, expected 00001", req);
    end
    drive(1'b0, BODY, 4'h0, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({req, route_valid, drop, route_err, cfg_pending} !== 9'b0) begin
      errors++; $display("FAIL rst_mid: got req=%b rv=%b drop=%b err=%b pend=%b, expected all zero",
                         req, route_valid, drop, route_err, cfg_pending);
    end
    drive(1'b0, HDR, 4'b0111, 1'b0); tick();
    checks++;
    if (req !== 5'b00010) begin
      errors++; $display("FAIL rst_cfg_restored: got req=%b, expected 00010", req);
    end
    drive(1'b0, TAIL, 4'h0, 1'b1); tick();
  endtask

  task automatic test_random();
    logic [8:0] got, exp;
    Rxy_rst = 8'($urandom); Cx_rst = 4'($urandom);
    dr_rst = 2'($urandom); cur_addr_rst = 4'($urandom);
    for (int i = 0; i < 800; i++) begin
      rst = (i == 0) || ($urandom_range(0, 79) == 0);
      empty = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       flit_type = HDR;
        1:       flit_type = TAIL;
        2:       flit_type = BODY;
        default: flit_type = 3'b111;
      endcase
      dst_addr = 4'($urandom);
      flit_rd  = 1'($urandom);
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_Rxy  = 8'($urandom); cfg_Cx = 4'($urandom); cfg_dr = 2'($urandom);
      model_step();
      tick();
      got = {req, route_valid, drop, route_err, cfg_pending};
      exp = {m_req, m_rv, m_drop, m_err, m_pend};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: got {req,rv,drop,err,pend}=%b, expected %b", i, got, exp);
      end
    end
    rst = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_Rxy = '0; cfg_Cx = '0; cfg_dr = '0;
    Rxy_rst = 8'h00; Cx_rst = 4'hF; dr_rst = 2'd0; cur_addr_rst = 4'b0101;
    drive(1'b1, BODY, 4'h0, 1'b0);
    test_reset();
    test_routed_packet();
    test_diagonal();
    test_local();
    test_unroutable();
    test_deferred_cfg();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
